lfsr_rq_gen: RTL



---
 rtl/lfsr_rq_gen_if.sv | 50 +++++
 rtl/lfsr_rq_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rq_gen_if.sv
// -----------------------------------------------------------------------------
// lfsr_rq_gen_if
//
// Purpose : bundles the request/grant and control signals shared by the
//           pseudo-random request generator (lfsr_rq_gen) and whatever sits on
//           the arbiter side of it (the bus arbiter or a testbench).
//
// Parameters:
//   N_CH     number of request channels carried by the bundle
//
// Signals:
//   enable   global run enable                      (arbiter side -> generator)
//   density  request probability, density/16 per idle cycle (-> generator)
//   gnt      grant, one bit per channel             (-> generator)
//   rq       registered request, one bit per channel (generator ->)
//   err      sticky protocol-error flag per channel  (generator ->)
//   gnt_cnt  total grants accepted                  (generator ->)
//
// Modports:
//   master   the request generator (drives rq/err/gnt_cnt)
//   slave    the arbiter / stimulus side (drives enable/density/gnt)
// -----------------------------------------------------------------------------
interface lfsr_rq_gen_if #(
  parameter int N_CH = 4
);
  logic            enable;
  logic [3:0]      density;
  logic [N_CH-1:0] gnt;
  logic [N_CH-1:0] rq;
  logic [N_CH-1:0] err;
  logic [15:0]     gnt_cnt;

  modport master (
    input  enable,
    input  density,
    input  gnt,
    output rq,
    output err,
    output gnt_cnt
  );

  modport slave (
    output enable,
    output density,
    output gnt,
    input  rq,
    input  err,
    input  gnt_cnt
  );
endinterface : lfsr_rq_gen_if

// File: rtl/lfsr_rq_gen.sv
// -----------------------------------------------------------------------------
// lfsr_rq_gen
//
// Purpose : multi-channel pseudo-random bus-request generator used as arbiter
//           stimulus / traffic model. Every channel owns a Fibonacci LFSR, a
//           request FSM (IDLE -> REQ -> OWN -> BACKOFF -> IDLE) and a full
//           request/grant handshake. A channel raises rq with probability
//           density/16 per idle cycle, holds it until granted, keeps the bus
//           for a pseudo-random 1..2^HOLD_W cycles, then backs off for
//           BACKOFF cycles.
//
// Parameters:
//   N_CH     number of independent channels (1..16)
//   WIDTH    LFSR width in bits (4..32)
//   TAPS     feedback tap mask, bit i set = lfsr[i] is tapped
//   SEED     base seed; channel c uses SEED ^ c, or 1 if that is zero
//   HOLD_W   ownership-length field width (HOLD_W <= WIDTH)
//   BACKOFF  idle cycles forced after each ownership (>= 1)
//
// Ports:
//   clk      clock
//   rst      asynchronous reset, active-high
//   bus      lfsr_rq_gen_if.master: enable, density, gnt in; rq, err,
//            gnt_cnt out
//
// Build option:
//   LFSR_RQ_GEN_STATS_EN  when defined, gnt_cnt counts REQ->OWN transitions
//                         (summed over channels, saturating at 16'hFFFF);
//                         otherwise gnt_cnt is tied to zero and no counter
//                         logic exists.
// -----------------------------------------------------------------------------
module lfsr_rq_gen #(
  parameter int               N_CH    = 4,
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] TAPS    = 8'hB8,
  parameter logic [WIDTH-1:0] SEED    = 8'h01,
  parameter int               HOLD_W  = 3,
  parameter int               BACKOFF = 2
) (
  input  logic          clk,
  input  logic          rst,
  lfsr_rq_gen_if.master bus
);

  // Width of the backoff down-counter; it only ever holds BACKOFF-1..0.
  localparam int BO_W = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_OWN     = 2'd2,
    ST_BACKOFF = 2'd3
  } state_e;

  // Per-channel seed. An all-zero LFSR would lock up, so a zero result is
  // replaced by 1.
  function automatic logic [WIDTH-1:0] chan_seed(input int c);
    logic [WIDTH-1:0] s;
    s = SEED ^ WIDTH'(c);
    if (s == '0) begin
      s = WIDTH'(1);
    end
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Per-channel state
  // ---------------------------------------------------------------------------
  state_e            state_q [N_CH];
  state_e            state_d [N_CH];
  logic [WIDTH-1:0]  lfsr_q  [N_CH];
  logic [WIDTH-1:0]  lfsr_d  [N_CH];
  logic [HOLD_W-1:0] own_q   [N_CH];
  logic [HOLD_W-1:0] own_d   [N_CH];
  logic [BO_W-1:0]   bo_q    [N_CH];
  logic [BO_W-1:0]   bo_d    [N_CH];
  logic [N_CH-1:0]   rq_q;
  logic [N_CH-1:0]   rq_d;
  logic [N_CH-1:0]   err_q;
  logic [N_CH-1:0]   err_d;
  logic [N_CH-1:0]   hit;

  // Request decision from the top nibble of the current (pre-shift) LFSR
  // value. density=0 can never hit; density=15 misses only on nibble 4'hF.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      hit[c] = (lfsr_q[c][WIDTH-1 -: 4] < bus.density);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: LFSR, channel FSM, counters, request and error flags
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      // NOTE: every variable written here gets a hold-value default first, so
      // no path through the case statement can leave one unassigned and infer
      // a latch.
      state_d[c] = state_q[c];
      lfsr_d[c]  = lfsr_q[c];
      own_d[c]   = own_q[c];
      bo_d[c]    = bo_q[c];
      err_d[c]   = err_q[c];

      // The LFSR runs in every state but only while enabled. A zero register
      // (unreachable from a valid seed, but cheap to recover from) reloads
      // the channel seed instead of shifting.
      if (bus.enable) begin
        if (lfsr_q[c] == '0) begin
          lfsr_d[c] = chan_seed(c);
        end else begin
          lfsr_d[c] = {lfsr_q[c][WIDTH-2:0], ^(lfsr_q[c] & TAPS)};
        end
      end

      case (state_q[c])
        ST_IDLE: begin
          // A grant here is a protocol error; it is flagged and otherwise
          // has no effect on the channel.
          if (bus.gnt[c]) begin
            err_d[c] = 1'b1;
          end
          if (bus.enable && hit[c]) begin
            state_d[c] = ST_REQ;
          end
        end

        ST_REQ: begin
          // The grant wins over a simultaneous enable drop.
          if (bus.gnt[c]) begin
            state_d[c] = ST_OWN;
            own_d[c]   = lfsr_q[c][HOLD_W-1:0];
          end else if (!bus.enable) begin
            state_d[c] = ST_IDLE;
          end
        end

        ST_OWN: begin
          // Ownership always runs to completion, regardless of enable, and
          // lasts own_cnt_initial+1 cycles. Grants here are legal and ignored.
          if (own_q[c] == '0) begin
            state_d[c] = ST_BACKOFF;
            bo_d[c]    = BO_W'(BACKOFF - 1);
          end else begin
            own_d[c] = own_q[c] - 1'b1;
          end
        end

        ST_BACKOFF: begin
          if (bus.gnt[c]) begin
            err_d[c] = 1'b1;
          end
          // Backoff counts down even while disabled.
          if (bo_q[c] == '0) begin
            state_d[c] = ST_IDLE;
          end else begin
            bo_d[c] = bo_q[c] - 1'b1;
          end
        end

        default: begin
          state_d[c] = ST_IDLE;
        end
      endcase

      // rq is a register that mirrors "state is REQ or OWN", so it is computed
      // from the next state and changes on the same edge as the state.
      rq_d[c] = (state_d[c] == ST_REQ) || (state_d[c] == ST_OWN);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the per-channel arrays are working state, not storage memories,
      // so every entry is reset explicitly; each LFSR must start from its own
      // seed.
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= ST_IDLE;
        lfsr_q[c]  <= chan_seed(c);
        own_q[c]   <= '0;
        bo_q[c]    <= '0;
      end
      rq_q  <= '0;
      err_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      own_q   <= own_d;
      bo_q    <= bo_d;
      rq_q    <= rq_d;
      err_q   <= err_d;
    end
  end

  assign bus.rq  = rq_q;
  assign bus.err = err_q;

  // ---------------------------------------------------------------------------
  // Grant statistics
  // ---------------------------------------------------------------------------
`ifdef LFSR_RQ_GEN_STATS_EN
  logic [N_CH-1:0] take;
  logic [4:0]      n_take;
  logic [16:0]     cnt_sum;
  logic [15:0]     gnt_cnt_q;
  logic [15:0]     gnt_cnt_d;

  // A grant is accepted on every REQ->OWN transition.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      take[c] = (state_q[c] == ST_REQ) && (state_d[c] == ST_OWN);
    end
  end

  // Several channels may be granted in the same cycle; add them all, then
  // saturate using the carry out of the 17-bit sum.
  always_comb begin
    n_take = '0;
    for (int c = 0; c < N_CH; c++) begin
      n_take = n_take + 5'(take[c]);
    end
    cnt_sum   = {1'b0, gnt_cnt_q} + 17'(n_take);
    gnt_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt_q <= '0;
    end else begin
      gnt_cnt_q <= gnt_cnt_d;
    end
  end

  assign bus.gnt_cnt = gnt_cnt_q;
`else
  assign bus.gnt_cnt = 16'h0000;
`endif

endmodule : lfsr_rq_gen
